// File: rtl/barrido_display.sv
// -----------------------------------------------------------------------------
// barrido_display
//
// Time-multiplexed scanner for a multi-digit display. A prescaler divides clk
// so that each of the 2**N digits is shown for COUNT_MAX clock cycles. The
// digit index rotates 0..2**N-1 and then back to 0. The matching nibble of
// `datos` is presented on `digito`.
//
// Parameters
//   N            digit-index width; 2**N digits are scanned
//   COUNT_MAX    clk cycles per digit slot (1..2**20)
//   BLANK_CYCLES blanking length after each index change (1..COUNT_MAX-1);
//                used only when BARRIDO_BLANKING_EN is defined
//
// Optional feature
//   BARRIDO_BLANKING_EN  when defined, `valido` drops for BLANK_CYCLES cycles
//                        every time the index changes (anti-ghosting). When it
//                        is undefined, `valido` is 1 on every cycle after
//                        reset release.
//
// Ports
//   clk      in   sole clock, rising edge
//   reset_n  in   synchronous active-low reset; overrides everything
//   enable   in   1 = scan advances, 0 = prescaler and index frozen
//   datos    in   packed nibbles, digit k at [4k+3:4k]
//   indice   out  current digit index (feeds a one-hot digit decoder)
//   digito   out  nibble of datos selected by indice
//   avance   out  one-cycle pulse on the first cycle of a new digit slot
//   valido   out  1 = digito/indice may light the display
//
// All outputs come straight from flip-flops.
// -----------------------------------------------------------------------------
module barrido_display #(
    parameter int unsigned N            = 3,
    parameter int unsigned COUNT_MAX    = 100000,
    parameter int unsigned BLANK_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic [4*(2**N)-1:0]   datos,
    output logic [N-1:0]          indice,
    output logic [3:0]            digito,
    output logic                  avance,
    output logic                  valido
);

    // A single-cycle slot still needs a 1-bit prescaler, which never leaves 0.
    localparam int unsigned  PW         = (COUNT_MAX > 1) ? $clog2(COUNT_MAX) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(COUNT_MAX - 1);

    logic [PW-1:0] presc_q,  presc_d;
    logic [N-1:0]  indice_q, indice_d;
    logic [3:0]    digito_q, digito_d;
    logic          avance_q, avance_d;
    logic          valido_q, valido_d;
    logic          slot_end;

`ifdef BARRIDO_BLANKING_EN
    localparam int unsigned  BW       = $clog2(BLANK_CYCLES + 1);
    localparam logic [BW-1:0] BLANK_LD = BW'(BLANK_CYCLES);

    logic [BW-1:0] blank_q, blank_d;
`endif

    always_comb begin
        slot_end = enable && (presc_q == PRESC_LAST);

        presc_d  = presc_q;
        indice_d = indice_q;
        avance_d = 1'b0;

        if (slot_end) begin
            presc_d  = '0;
            indice_d = indice_q + N'(1);  // natural wrap 2**N-1 -> 0
            avance_d = 1'b1;
        end else if (enable) begin
            presc_d  = presc_q + PW'(1);
        end

        // Select with the index that will be displayed after this edge, so
        // digito and indice always describe the same digit.
        digito_d = 4'(datos >> {indice_d, 2'b00});

`ifdef BARRIDO_BLANKING_EN
        // The index changes exactly on slot_end edges, so that is where the
        // blanking window restarts. Counting down ignores enable.
        if (slot_end) begin
            blank_d = BLANK_LD;
        end else if (blank_q != '0) begin
            blank_d = blank_q - BW'(1);
        end else begin
            blank_d = '0;
        end
        // Registered valido reflects the counter value after this edge.
        valido_d = (blank_d == '0);
`else
        valido_d = 1'b1;
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            presc_q  <= '0;
            indice_q <= '0;
            digito_q <= '0;
            avance_q <= 1'b0;
            valido_q <= 1'b0;
`ifdef BARRIDO_BLANKING_EN
            blank_q  <= '0;
`endif
        end else begin
            presc_q  <= presc_d;
            indice_q <= indice_d;
            digito_q <= digito_d;
            avance_q <= avance_d;
            valido_q <= valido_d;
`ifdef BARRIDO_BLANKING_EN
            blank_q  <= blank_d;
`endif
        end
    end

    assign indice = indice_q;
    assign digito = digito_q;
    assign avance = avance_q;
    assign valido = valido_q;

endmodule

// File: tb/tb_barrido_display.sv
// -----------------------------------------------------------------------------
// tb_barrido_display
//
// Drives barrido_display (N=3, COUNT_MAX=4, BLANK_CYCLES=2) with directed
// scenarios followed by random enable/datos/reset traffic. The reference
// model counts enabled edges since reset and derives index, pulse and
// blanking from that count arithmetically.
// -----------------------------------------------------------------------------
module tb_barrido_display;

    localparam int N  = 3;
    localparam int CM = 4;
    localparam int BL = 2;
    localparam int ND = 2 ** N;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic [31:0] datos;
    logic [N-1:0] indice;
    logic [3:0]  digito;
    logic        avance;
    logic        valido;

    always #5 clk = ~clk;

    barrido_display #(
        .N            (N),
        .COUNT_MAX    (CM),
        .BLANK_CYCLES (BL)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (enable),
        .datos   (datos),
        .indice  (indice),
        .digito  (digito),
        .avance  (avance),
        .valido  (valido)
    );

    // ---------------- scoreboard ----------------
    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];   // expected indice for every predicted avance pulse

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int          m_en_count;    // enabled edges since last reset
    int          m_since_adv;   // edges since last avance
    logic [2:0]  m_idx;
    logic [3:0]  m_dig;
    logic        m_adv;
    logic        m_val;

    function automatic logic [3:0] nibble(input logic [31:0] d, input int k);
        logic [31:0] t;
        t = d >> (4 * k);
        return t[3:0];
    endfunction

    task automatic model_edge(input logic rst_n, input logic en, input logic [31:0] d);
        if (!rst_n) begin
            m_en_count  = 0;
            m_since_adv = BL;
            m_idx       = '0;
            m_dig       = '0;
            m_adv       = 1'b0;
            m_val       = 1'b0;
        end else begin
            m_adv = 1'b0;
            if (en) begin
                m_en_count++;
                m_adv = (m_en_count % CM) == 0;
            end
            m_idx = 3'((m_en_count / CM) % ND);
            m_dig = nibble(d, int'(m_idx));
            if (m_adv) m_since_adv = 0;
            else if (m_since_adv < BL) m_since_adv++;
`ifdef BARRIDO_BLANKING_EN
            m_val = (m_since_adv >= BL);
`else
            m_val = 1'b1;
`endif
            if (m_adv) exp_q.push_back(32'(m_idx));
        end
    endtask

    // ---------------- driver ----------------
    // Inputs change just after a falling edge; outputs are checked on the
    // following falling edge, well away from the active rising edge.
    task automatic tick(input logic rst_n, input logic en, input logic [31:0] d);
        logic [31:0] e;
        reset_n = rst_n;
        enable  = en;
        datos   = d;
        @(posedge clk);
        model_edge(rst_n, en, d);
        @(negedge clk);
        check("indice", 32'(indice), 32'(m_idx));
        check("digito", 32'(digito), 32'(m_dig));
        check("avance", 32'(avance), 32'(m_adv));
        check("valido", 32'(valido), 32'(m_val));
        if (avance) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_avance", 32'(avance), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("sb_avance_indice", 32'(indice), e);
            end
        end
        check("sb_pending", 32'(exp_q.size()), 32'd0);
        if (exp_q.size() != 0) exp_q.delete();
    endtask

    task automatic run_until_idx(input int target, input logic [31:0] d);
        int n = 0;
        while (int'(m_idx) != target && n < 64) begin
            tick(1'b1, 1'b1, d);
            n++;
        end
        if (int'(m_idx) != target) check("wait_idx_timeout", 32'(m_idx), 32'(target));
    endtask

    task automatic run_until_presc(input int target, input logic [31:0] d);
        int n = 0;
        while ((m_en_count % CM) != target && n < 16) begin
            tick(1'b1, 1'b1, d);
            n++;
        end
        if ((m_en_count % CM) != target) check("wait_presc_timeout", 32'(m_en_count % CM), 32'(target));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] d;
        logic        en;
        logic        rst;

        reset_n = 1'b0;
        enable  = 1'b0;
        datos   = '0;
        m_en_count = 0; m_since_adv = BL;
        m_idx = '0; m_dig = '0; m_adv = 1'b0; m_val = 1'b0;

        // Reset for three cycles, with enable high to show it is overridden.
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 32'h7654_3210);

        // Full scan and wrap past digit 7.
        d = 32'h7654_3210;
        for (int i = 0; i < 40; i++) tick(1'b1, 1'b1, d);

        // Freeze with prescaler at 2 for five cycles, then resume.
        run_until_presc(2, d);
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, d);
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b1, d);

        // Change datos while digit 3 is shown.
        run_until_idx(3, d);
        d = 32'hFFFF_AFFF;
        tick(1'b1, 1'b1, d);
        tick(1'b1, 1'b1, d);

        // One-cycle reset while digit 5 is shown, then a fresh slot.
        d = 32'h7654_3210;
        run_until_idx(5, d);
        tick(1'b0, 1'b1, d);
        for (int i = 0; i < 12; i++) tick(1'b1, 1'b1, d);

        // Randomized traffic: mostly enabled, occasional datos change and reset.
        for (int i = 0; i < 400; i++) begin
            en  = ($urandom_range(0, 9) < 7);
            rst = ($urandom_range(0, 59) != 0);
            if ($urandom_range(0, 7) == 0) d = $urandom;
            tick(rst, en, d);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/barrido_display.md
BARRIDO_DISPLAY -- requirements
Module: barrido_display

Interface
REQ-001 Parameter N, default 3: digit-index width; 2**N digits scanned.
REQ-002 Parameter COUNT_MAX, default 100000: clk cycles per digit slot; legal range 1..2**20.
REQ-003 Parameter BLANK_CYCLES, default 16: blanking length; used only with BARRIDO_BLANKING_EN; legal range 1..COUNT_MAX-1.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset_n  input  1  reset: synchronous, active-low.
REQ-006 enable  input  1  1 = scan advances; 0 = scan frozen.
REQ-007 datos  input  4*2**N  packed nibbles; digit k occupies bits [4k+3:4k].
REQ-008 indice  output  N  current digit index; drives the N-bit input of the one-hot digit decoder downstream.
REQ-009 digito  output  4  nibble of datos selected by indice.
REQ-010 avance  output  1  one-cycle pulse marking the first cycle of a new digit slot.
REQ-011 valido  output  1  1 = digito/indice stable and may light the display.

Function
REQ-012 Internal prescaler counts 0..COUNT_MAX-1, incrementing on each edge with enable=1.
REQ-013 On an edge with enable=1 and prescaler=COUNT_MAX-1: prescaler->0, indice->indice+1, avance->1.
REQ-014 avance SHALL be 0 on every other edge; never high for 2 consecutive cycles unless COUNT_MAX=1.
REQ-015 COUNT_MAX=1: avance SHALL stay high and indice SHALL increment on every enabled edge.
REQ-016 indice wraps 2**N-1 -> 0 with no extra cycle and no skipped value.
REQ-017 enable=0: prescaler and indice hold; avance->0; digito keeps tracking datos.
REQ-018 digito registered: each edge loads datos[4*i+3:4*i], i = indice value after that edge; digito always matches displayed indice; a datos change is visible on digito 1 cycle later.
REQ-019 Without BARRIDO_BLANKING_EN, valido SHALL be 1 on every cycle following the first edge with reset_n=1.
REQ-020 All outputs SHALL be driven directly from flip-flops; no combinational input-to-output path.

Reset
REQ-021 Edge with reset_n=0: prescaler=0, indice=0, digito=0, avance=0, valido=0, blanking counter=0.
REQ-022 reset_n=0 SHALL override enable and any pending wrap on the same edge.
REQ-023 Reset asserted mid-slot SHALL restart scanning at digit 0 with a full COUNT_MAX slot after release.

Configuration
REQ-024 Macro BARRIDO_BLANKING_EN, when defined, SHALL add a blanking down-counter loaded with BLANK_CYCLES on every edge where indice changes.
REQ-025 With BARRIDO_BLANKING_EN: valido SHALL be 0 while the blanking counter is nonzero and 1 otherwise (after reset release); the counter decrements every cycle regardless of enable.
REQ-026 Without BARRIDO_BLANKING_EN: no blanking counter is synthesized, BLANK_CYCLES is ignored, and REQ-019 applies.

Verification (N=3, COUNT_MAX=4, BLANK_CYCLES=2)
REQ-027 reset_n=0 3 cycles, then enable=1, datos=32'h76543210 -> avance every 4th cycle; indice 0,1,...,7; digito equals indice each cycle.
REQ-028 Continue past indice=7 -> next avance gives indice=0, digito=0; no cycle with indice outside 0..7.
REQ-029 Drop enable for 5 cycles with prescaler=2 -> indice/prescaler frozen, avance=0; after re-enable, avance on 2nd enabled edge.
REQ-030 At indice=3, change datos to 32'hFFFF_AFFF -> digito=4'hA exactly 1 cycle later, indice unchanged.
REQ-031 reset_n=0 for 1 cycle with indice=5, enable=1 -> next cycle indice=0, digito=0, avance=0, valido=0; first avance 4 cycles after release.
REQ-032 Build with BARRIDO_BLANKING_EN -> valido=0 for exactly 2 cycles starting each cycle avance=1, else 1; build without -> valido constantly 1 after reset.
